// File: rtl/traffic_lights_timed_if.sv
// Purpose: sensor/request inputs and light outputs of the timed traffic-light
// controller, bundled as one port.
//   car_ns   : north-south vehicle present (level)
//   car_ew   : east-west vehicle present (latched as demand)
//   ped_req  : pedestrian button (latched as demand)
//   flash_en : flashing-yellow mode request (level)
//   lights   : {R_NS,Y_NS,G_NS,R_EW,Y_EW,G_EW}
//   ped_walk : walk indication
//   state_o  : current state code for debug
// master drives the requests and observes the lights; slave is the controller.
interface traffic_lights_timed_if;
    logic       car_ns;
    logic       car_ew;
    logic       ped_req;
    logic       flash_en;
    logic [5:0] lights;
    logic       ped_walk;
    logic [2:0] state_o;

    modport master (
        output car_ns, car_ew, ped_req, flash_en,
        input  lights, ped_walk, state_o
    );

    modport slave (
        input  car_ns, car_ew, ped_req, flash_en,
        output lights, ped_walk, state_o
    );
endinterface

// File: rtl/traffic_lights_timed.sv
// Purpose: two-direction traffic-light controller with minimum/maximum green
// times, yellow and all-red clearance, pedestrian walk during all-red and a
// flashing-yellow override mode. North-south green is the rest state.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : requests in, lights/ped_walk/state_o out (all outputs registered)
module traffic_lights_timed #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_MIN  = 4,
    parameter int unsigned GREEN_MAX  = 16,
    parameter int unsigned YELLOW_T   = 2,
    parameter int unsigned ALLRED_T   = 1,
    parameter int unsigned WALK_T     = 4,
    parameter int unsigned FLASH_HALF = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    traffic_lights_timed_if.slave  bus
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        FLASH     = 3'd6
    } state_e;

    // Last timer value of each timed phase
    localparam logic [CNT_W-1:0] GMIN_END  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_END   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_END  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_END  = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] FLASH_END = CNT_W'(2 * FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] FLASH_ON  = CNT_W'(FLASH_HALF);

    localparam logic [5:0] LT_NS_GREEN  = 6'b001_100;
    localparam logic [5:0] LT_NS_YELLOW = 6'b010_100;
    localparam logic [5:0] LT_ALL_RED   = 6'b100_100;
    localparam logic [5:0] LT_EW_GREEN  = 6'b100_001;
    localparam logic [5:0] LT_EW_YELLOW = 6'b100_010;
    localparam logic [5:0] LT_FLASH_ON  = 6'b010_010;
    localparam logic [5:0] LT_DARK      = 6'b000_000;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               ew_pend_q, ew_pend_d;
    logic               ped_pend_q, ped_pend_d;
    logic [5:0]         lights_q, lights_d;
    logic               ped_walk_q, ped_walk_d;
    logic               state_chg;
    logic [CNT_W-1:0]   ared_end;

    // Next-state selection; flash request overrides every other transition
    always_comb begin
        state_d  = state_q;
        ared_end = ped_walk_q ? WALK_END : ARED_END;
        if (bus.flash_en) begin
            state_d = FLASH;
        end else begin
            case (state_q)
                NS_GREEN: begin
                    if (timer_q >= GMIN_END && (ew_pend_q || bus.car_ew || ped_pend_q))
                        state_d = NS_YELLOW;
                end
                NS_YELLOW: if (timer_q == YEL_END)  state_d = ALL_RED_A;
                ALL_RED_A: if (timer_q == ared_end) state_d = EW_GREEN;
                EW_GREEN: begin
                    if ((timer_q >= GMIN_END && (bus.car_ns || !bus.car_ew || ped_pend_q))
                        || timer_q == GMAX_END)
                        state_d = EW_YELLOW;
                end
                EW_YELLOW: if (timer_q == YEL_END)  state_d = ALL_RED_B;
                ALL_RED_B: if (timer_q == ared_end) state_d = NS_GREEN;
                FLASH:     state_d = ALL_RED_B;
                default:   state_d = NS_GREEN;
            endcase
        end
    end

    assign state_chg = (state_d != state_q);

    // Phase timer: restarts on every state change, saturates in green, wraps in flash
    always_comb begin
        timer_d = timer_q + CNT_W'(1);
        if (state_chg) begin
            timer_d = '0;
        end else if ((state_q == NS_GREEN || state_q == EW_GREEN) && timer_q >= GMAX_END) begin
            timer_d = timer_q;
        end else if (state_q == FLASH && timer_q >= FLASH_END) begin
            timer_d = '0;
        end
    end

    // Demand latches; button presses during an active walk are ignored
    always_comb begin
        ew_pend_d  = ew_pend_q | bus.car_ew;
        ped_pend_d = ped_pend_q | (bus.ped_req & ~ped_walk_q);
        if (state_chg && state_d == EW_GREEN)
            ew_pend_d = 1'b0;
        if (state_chg && ped_walk_q)
            ped_pend_d = 1'b0;
    end

    // Outputs decoded from the next registered values so they land with the state
    always_comb begin
        ped_walk_d = 1'b0;
        lights_d   = LT_NS_GREEN;
        if (state_d == ALL_RED_A || state_d == ALL_RED_B)
            ped_walk_d = state_chg ? ped_pend_d : ped_walk_q;
        case (state_d)
            NS_GREEN:  lights_d = LT_NS_GREEN;
            NS_YELLOW: lights_d = LT_NS_YELLOW;
            ALL_RED_A: lights_d = LT_ALL_RED;
            EW_GREEN:  lights_d = LT_EW_GREEN;
            EW_YELLOW: lights_d = LT_EW_YELLOW;
            ALL_RED_B: lights_d = LT_ALL_RED;
            FLASH:     lights_d = (timer_d < FLASH_ON) ? LT_FLASH_ON : LT_DARK;
            default:   lights_d = LT_NS_GREEN;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= NS_GREEN;
            timer_q    <= '0;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
            lights_q   <= LT_NS_GREEN;
            ped_walk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
            lights_q   <= lights_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign bus.lights   = lights_q;
    assign bus.ped_walk = ped_walk_q;
    assign bus.state_o  = 3'(state_q);

endmodule
